// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe
//
// Registered execute stage. Selects the ALU B operand, performs the
// operation and registers the result together with zero/branch flags
// into an EX/MEM output register with a valid/stall/flush handshake.
//
// Optional feature macro: EX_MUL_EN
//   Defined   - alu_op 10 (MUL) runs on an iterative shift-add multiplier
//               that takes WIDTH cycles and holds ready low meanwhile.
//   Undefined - no multiplier exists, the FSM stays in IDLE and alu_op 10
//               is a reserved single-cycle op producing 0.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  ID/EX offers an op this cycle
//   ready     stage accepts an op this cycle (combinational)
//   alub_sel  1: B = ext, 0: B = rd2
//   a         operand A
//   rd2       register operand
//   ext       sign-extended immediate
//   alu_op    operation code
//   stall_in  downstream cannot accept; hold the output register
//   flush     kill held result and any op in flight
//   out_valid output register holds a valid result
//   c         registered result
//   zero      registered, 1 when c == 0
//   branch    registered, 01 when c == 0, 10 when c negative, else 00
module ex_stage_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             ready,
    input  logic             alub_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] ext,
    input  logic [3:0]       alu_op,
    input  logic             stall_in,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic [1:0]       branch
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] b_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res_next;
    logic             res_zero;
    logic [1:0]       res_branch;
    logic             accept;
    logic             start_mul;
    logic             mul_busy;
    logic             mul_done;

    assign b_op  = alub_sel ? ext : rd2;
    assign shamt = b_op[SHW-1:0];

    // Single-cycle ALU; reserved codes (and MUL, which is handled by the
    // multiplier when present) produce 0.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = a + b_op;
            OP_SUB:  alu_res = a - b_op;
            OP_AND:  alu_res = a & b_op;
            OP_OR:   alu_res = a | b_op;
            OP_XOR:  alu_res = a ^ b_op;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b_op))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b_op)};
            default: alu_res = '0;
        endcase
    end

    // A busy multiplier, a held result under stall, or a flush all refuse
    // new work.
    assign ready  = (state == IDLE) && !(out_valid && stall_in) && !flush;
    assign accept = in_valid && ready;

`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_step;
    logic [SHW-1:0]   cnt;

    // One shift-add iteration: add the shifted multiplicand when the
    // current multiplier LSB is set. On the last iteration this sum is the
    // final product and goes straight into the output register.
    assign mul_step  = acc + (mplier[0] ? mcand : '0);
    assign start_mul = accept && (alu_op == OP_MUL);
    assign mul_busy  = (state == MUL);
    assign mul_done  = mul_busy && (cnt == SHW'(WIDTH - 1));
    assign res_next  = mul_busy ? mul_step : alu_res;

    // Multiplier FSM and datapath; flush and reset abandon the multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == MUL) begin
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mul_done) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start_mul) begin
            mcand  <= a;
            mplier <= b_op;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
        end
    end
`else
    assign state     = IDLE;
    assign start_mul = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign res_next  = alu_res;
`endif

    assign res_zero   = (res_next == '0);
    assign res_branch = res_zero ? 2'b01 : (res_next[WIDTH-1] ? 2'b10 : 2'b00);

    // EX/MEM output register. Priority: reset, flush, multiplier
    // completion/busy, downstream stall, accept. Without a new result the
    // data holds and only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            zero      <= 1'b1;
            branch    <= 2'b01;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            c         <= res_next;
            zero      <= res_zero;
            branch    <= res_branch;
        end else if (mul_busy) begin
            out_valid <= 1'b0;
        end else if (out_valid && stall_in) begin
            out_valid <= out_valid;
        end else if (accept && !start_mul) begin
            out_valid <= 1'b1;
            c         <= res_next;
            zero      <= res_zero;
            branch    <= res_branch;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe
//
// Self-checking bench for ex_stage_pipe (WIDTH = 32). Table-driven ALU
// vectors, hand-written stall/flush/multiply sequences, then randomized
// traffic compared against a behavioural model of the stage.
// Honours EX_MUL_EN the same way the design does.
module tb_ex_stage_pipe;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              ready;
    logic              alub_sel;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  ext;
    logic [3:0]        alu_op;
    logic              stall_in;
    logic              flush;
    logic              out_valid;
    logic [WIDTH-1:0]  c;
    logic              zero;
    logic [1:0]        branch;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] r2;
        logic [31:0] ex;
        logic        sel;
        logic [31:0] exp_c;
    } vec_t;

    vec_t vecs[13];

    ex_stage_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ready     (ready),
        .alub_sel  (alub_sel),
        .a         (a),
        .rd2       (rd2),
        .ext       (ext),
        .alu_op    (alu_op),
        .stall_in  (stall_in),
        .flush     (flush),
        .out_valid (out_valid),
        .c         (c),
        .zero      (zero),
        .branch    (branch)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Branch flags as defined for a result value.
    function automatic logic [1:0] branch_of(input logic [31:0] v);
        if (v == 32'd0) return 2'b01;
        if (v[31])      return 2'b10;
        return 2'b00;
    endfunction

    // Reference ALU written straight from the operation table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        sh = y % 32;
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x << sh;
            4'd6: return x >> sh;
            4'd7: return 32'($signed(x) >>> sh);
            4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Drive every input, then let combinational ready settle.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] av,
                                 input logic [31:0] r2, input logic [31:0] ex, input logic sel,
                                 input logic st, input logic fl);
        in_valid = v;
        alu_op   = op;
        a        = av;
        rd2      = r2;
        ext      = ex;
        alub_sel = sel;
        stall_in = st;
        flush    = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string name, input logic [31:0] exp_c, input logic exp_v);
        checkOutput({name, ".c"}, c, exp_c);
        checkOutput({name, ".zero"}, zero, exp_c == 32'd0);
        checkOutput({name, ".branch"}, branch, branch_of(exp_c));
        checkOutput({name, ".out_valid"}, out_valid, exp_v);
    endtask

    // Randomized traffic against a behavioural model of the handshake.
    task automatic randomPhase(input int n);
        logic [31:0] m_c;
        logic        m_valid;
        logic        exp_ready;
        logic [3:0]  op;
        logic        v, st, fl, sel;
        logic [31:0] av, r2, ex, bv;
        rst = 1'b1;
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        m_c     = 32'd0;
        m_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
            if (op == 4'd10) op = 4'd0;
`endif
            v   = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 9) < 1);
            sel = 1'($urandom_range(0, 1));
            av  = $urandom;
            r2  = $urandom;
            ex  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            applyStimulus(v, op, av, r2, ex, sel, st, fl);
            exp_ready = !(m_valid && st) && !fl;
            checkOutput("rand.ready", ready, exp_ready);
            bv = sel ? ex : r2;
            if (fl) begin
                m_valid = 1'b0;
            end else if (m_valid && st) begin
                m_valid = 1'b1;
            end else if (v && exp_ready) begin
                m_c     = ref_alu(op, av, bv);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            tick();
            checkResult("rand", m_c, m_valid);
        end
    endtask

    initial begin
        vecs[0]  = '{"add",      4'd0, 32'd5,        32'd7,        32'd0, 1'b0, 32'd12};
        vecs[1]  = '{"sub_zero", 4'd1, 32'd3,        32'd0,        32'd3, 1'b1, 32'd0};
        vecs[2]  = '{"sub_neg",  4'd1, 32'd1,        32'd2,        32'd0, 1'b0, 32'hFFFF_FFFF};
        vecs[3]  = '{"add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1,       32'd0, 1'b0, 32'd0};
        vecs[4]  = '{"sra",      4'd7, 32'h8000_0000, 32'd0,       32'd4, 1'b1, 32'hF800_0000};
        vecs[5]  = '{"slt",      4'd8, 32'hFFFF_FFFF, 32'd1,       32'd0, 1'b0, 32'd1};
        vecs[6]  = '{"sltu",     4'd9, 32'hFFFF_FFFF, 32'd1,       32'd0, 1'b0, 32'd0};
        vecs[7]  = '{"and",      4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'h00F0_00F0};
        vecs[8]  = '{"reserved", 4'd13, 32'd5,       32'd7,        32'd0, 1'b0, 32'd0};
        vecs[9]  = '{"or",       4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'hFFF0_FFF0};
        vecs[10] = '{"xor",      4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 32'hFF00_FF00};
        vecs[11] = '{"sll_mask", 4'd5, 32'd1,        32'h25,       32'd0, 1'b0, 32'h20};
        vecs[12] = '{"srl",      4'd6, 32'h8000_0000, 32'd31,      32'd0, 1'b0, 32'd1};

        // Reset state
        rst = 1'b1;
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkResult("reset", 32'd0, 1'b0);
        checkOutput("reset.ready", ready, 1'b1);
        rst = 1'b0;

        // Back-to-back table vectors
        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].op, vecs[i].av, vecs[i].r2, vecs[i].ex, vecs[i].sel, 0, 0);
            checkOutput({vecs[i].name, ".ready"}, ready, 1'b1);
            tick();
            checkResult(vecs[i].name, vecs[i].exp_c, 1'b1);
        end

        // Idle cycle: valid drops, data holds
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();
        checkResult("idle_hold", 32'd1, 1'b0);

        // Stall for three cycles with a new op waiting
        applyStimulus(1, 4'd0, 32'd10, 32'd20, 0, 0, 0, 0);
        tick();
        checkResult("pre_stall", 32'd30, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'd0, 32'd1, 32'd1, 0, 0, 1, 0);
            checkOutput("stall.ready", ready, 1'b0);
            tick();
            checkResult("stall", 32'd30, 1'b1);
        end
        applyStimulus(1, 4'd0, 32'd1, 32'd1, 0, 0, 0, 0);
        checkOutput("unstall.ready", ready, 1'b1);
        tick();
        checkResult("unstall", 32'd2, 1'b1);

        // Flush overrides stall and blocks the offered op
        applyStimulus(1, 4'd0, 32'd7, 32'd7, 0, 0, 1, 1);
        checkOutput("flush.ready", ready, 1'b0);
        tick();
        checkOutput("flush.out_valid", out_valid, 1'b0);
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();
        checkResult("post_flush", 32'd2, 1'b0);

`ifdef EX_MUL_EN
        // Full multiply: ready low for WIDTH cycles, product at N+WIDTH+1
        applyStimulus(1, 4'd10, 32'h0001_0003, 32'd5, 0, 0, 0, 0);
        checkOutput("mul.accept_ready", ready, 1'b1);
        tick();
        applyStimulus(1, 4'd0, 32'd1, 32'd1, 0, 0, 0, 0);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput("mul.busy_ready", ready, 1'b0);
            checkOutput("mul.busy_valid", out_valid, 1'b0);
            tick();
        end
        checkResult("mul", 32'h0005_000F, 1'b1);
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        tick();

        // Flush at iteration 10 discards the multiply
        applyStimulus(1, 4'd10, 32'd3, 32'd7, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        repeat (9) tick();
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul_flush.out_valid", out_valid, 1'b0);
        checkOutput("mul_flush.ready", ready, 1'b1);
        repeat (40) tick();
        checkOutput("mul_flush.no_result", out_valid, 1'b0);

        // Reset mid-multiply aborts with no result
        applyStimulus(1, 4'd10, 32'd9, 32'd9, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResult("mul_reset", 32'd0, 1'b0);
        checkOutput("mul_reset.ready", ready, 1'b1);
        repeat (40) tick();
        checkOutput("mul_reset.no_result", out_valid, 1'b0);
`else
        // Without the multiplier, op 10 is a reserved single-cycle op
        applyStimulus(1, 4'd0, 32'd5, 32'd7, 0, 0, 0, 0);
        tick();
        checkResult("pre_op10", 32'd12, 1'b1);
        applyStimulus(1, 4'd10, 32'd3, 32'd4, 0, 0, 0, 0);
        checkOutput("op10.ready", ready, 1'b1);
        tick();
        checkResult("op10", 32'd0, 1'b1);
`endif

        randomPhase(300);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
